// File: rtl/dma_axi_rd_burst.sv
`default_nettype none
// ============================================================================
// Module : dma_axi_rd_burst
// Brief  : AXI4 read DMA; splits one command into capped, 4 KB-safe INCR bursts.
// Rev    : 1.0
// ============================================================================
module dma_axi_rd_burst #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  num_beats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arqos,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [LEN_W-1:0]  m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int SIZE   = $clog2(DATA_W / 8);
  localparam int BCNT_W = $clog2(MAX_BURST) + 1;
  localparam int CMP_W  = (CNT_W > 13) ? CNT_W : 13;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SIZE) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_remaining;
  logic [BCNT_W-1:0]   r_blen;
  logic [BCNT_W-1:0]   r_beat;
  logic [ADDR_W-1:0]   r_araddr;
  logic [LEN_W-1:0]    r_arlen;
  logic                r_arvalid;
  logic                r_done;
  logic                r_error;

  logic                w_beat_acc;
  logic                w_burst_last;
  logic [ADDR_W-1:0]   w_base_addr;
  logic [CNT_W-1:0]    w_base_rem;
  logic [12:0]         w_to_bound;
  logic [CMP_W-1:0]    w_min;
  logic [BCNT_W-1:0]   w_blen_nxt;

  assign w_beat_acc   = (r_state == S_DATA) && m_axi_rvalid && out_ready;
  assign w_burst_last = (r_beat == r_blen - 1'b1);

  // Address/remaining for the burst about to be issued: the new command in
  // IDLE, otherwise the position just past the burst now completing.
  always_comb begin
    w_base_addr = (r_state == S_IDLE) ? (start_addr & ALIGN_MASK)
                                      : r_addr + (ADDR_W'(r_blen) << SIZE);
    w_base_rem  = (r_state == S_IDLE) ? num_beats : r_remaining - CNT_W'(r_blen);
    w_to_bound  = (13'd4096 - {1'b0, w_base_addr[11:0]}) >> SIZE;
    w_min       = CMP_W'(MAX_BURST);
    if (CMP_W'(w_to_bound) < w_min) w_min = CMP_W'(w_to_bound);
    if (CMP_W'(w_base_rem) < w_min) w_min = CMP_W'(w_base_rem);
    w_blen_nxt  = BCNT_W'(w_min);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start && (num_beats != '0)) w_state_nxt = S_ADDR;
      S_ADDR: if (m_axi_arready) w_state_nxt = S_DATA;
      S_DATA: if (w_beat_acc && w_burst_last)
                w_state_nxt = (w_base_rem == '0) ? S_IDLE : S_ADDR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_beat      <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            if (num_beats == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= w_base_addr;
              r_remaining <= num_beats;
              r_blen      <= w_blen_nxt;
              r_beat      <= '0;
              r_araddr    <= w_base_addr;
              r_arlen     <= LEN_W'(w_blen_nxt - 1'b1);
              r_arvalid   <= 1'b1;
            end
          end
        end
        S_ADDR: if (m_axi_arready) r_arvalid <= 1'b0;
        S_DATA: begin
          if (w_beat_acc) begin
            r_beat <= r_beat + 1'b1;
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_burst_last)) r_error <= 1'b1;
            // Burst ends by beat count regardless of what rlast claimed.
            if (w_burst_last) begin
              r_addr      <= w_base_addr;
              r_remaining <= w_base_rem;
              r_beat      <= '0;
              if (w_base_rem == '0) begin
                r_done <= 1'b1;
              end else begin
                r_blen    <= w_blen_nxt;
                r_araddr  <= w_base_addr;
                r_arlen   <= LEN_W'(w_blen_nxt - 1'b1);
                r_arvalid <= 1'b1;
              end
            end
          end
        end
        default: r_arvalid <= 1'b0;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign error         = r_error;
  assign out_valid     = (r_state == S_DATA) && m_axi_rvalid;
  assign out_data      = m_axi_rdata;
  assign out_last      = out_valid && w_burst_last && (r_remaining == CNT_W'(r_blen));
  assign m_axi_rready  = (r_state == S_DATA) && out_ready;
  assign m_axi_arid    = '0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arqos   = 4'h0;
  assign m_axi_arcache = 4'h2;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = r_arvalid;
endmodule
`default_nettype wire

// File: tb/tb_dma_axi_rd_burst.sv
`default_nettype none
// Directed bench for dma_axi_rd_burst: AXI slave/stream sink model plus
// one task per scenario with hand-computed burst lists and data.
module tb_dma_axi_rd_burst;
  localparam int ADDR_W = 32, DATA_W = 32, LEN_W = 8, CNT_W = 16, MAX_BURST = 16, ID_W = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  num_beats = '0;
  logic              out_ready = 1'b1;
  logic              m_axi_arready = 1'b0;
  logic [DATA_W-1:0] m_axi_rdata = '0;
  logic [1:0]        m_axi_rresp = 2'b00;
  logic              m_axi_rlast = 1'b0;
  logic              m_axi_rvalid = 1'b0;
  wire               busy, done, error, out_valid, out_last;
  wire [DATA_W-1:0]  out_data;
  wire [ID_W-1:0]    m_axi_arid;
  wire               m_axi_arlock, m_axi_arvalid, m_axi_rready;
  wire [3:0]         m_axi_arqos, m_axi_arcache;
  wire [2:0]         m_axi_arprot, m_axi_arsize;
  wire [ADDR_W-1:0]  m_axi_araddr;
  wire [LEN_W-1:0]   m_axi_arlen;
  wire [1:0]         m_axi_arburst;

  dma_axi_rd_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .MAX_BURST(MAX_BURST), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .error(error),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .m_axi_arid(m_axi_arid), .m_axi_arlock(m_axi_arlock), .m_axi_arqos(m_axi_arqos),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, ar_delay = 0, ar_wait = 0;
  logic s_active = 1'b0;
  logic [31:0] s_addr = '0;
  int s_len = 0, s_beat = 0, s_gbeat = 0;
  int inj_rresp = 0, inj_rlast = 0;
  logic [31:0] ar_addr_q[$];
  int ar_len_q[$];
  logic [31:0] cap_data[$];
  bit cap_last[$];
  int done_cnt = 0, done_cyc = -1, last_cyc = -1, arv_cnt = 0, mirror_err = 0, stab_err = 0;
  logic err_at_done = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [7:0] hold_len = '0;
  bit hold_v = 1'b0;

  // Slave drives on the falling edge and observes handshakes just before the
  // rising edge, when every DUT input and output is settled.
  initial begin : slave
    forever begin
      @(negedge clk);
      cyc++;
      m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
      m_axi_rvalid  = s_active;
      m_axi_rdata   = s_addr + 32'(s_beat * 4);
      m_axi_rlast   = (s_beat == s_len) || (s_gbeat + 1 == inj_rlast);
      m_axi_rresp   = (s_gbeat + 1 == inj_rresp) ? 2'b10 : 2'b00;
      #3;
      if (rst) begin
        s_active = 1'b0; ar_wait = 0; hold_v = 1'b0;
      end else begin
        if (m_axi_arvalid) begin
          arv_cnt++;
          if (hold_v && (m_axi_araddr !== hold_addr || m_axi_arlen !== hold_len)) stab_err++;
          hold_addr = m_axi_araddr; hold_len = m_axi_arlen; hold_v = 1'b1;
          if (m_axi_arready) begin
            ar_addr_q.push_back(m_axi_araddr);
            ar_len_q.push_back(int'(m_axi_arlen));
            s_addr = m_axi_araddr; s_len = int'(m_axi_arlen); s_beat = 0;
            s_active = 1'b1; ar_wait = 0; hold_v = 1'b0;
          end else begin
            ar_wait++;
          end
        end
        if (busy && !m_axi_arvalid && (m_axi_rready !== out_ready)) mirror_err++;
        if (m_axi_rvalid && m_axi_rready) begin
          cap_data.push_back(out_data);
          cap_last.push_back(out_last);
          if (out_last) last_cyc = cyc;
          s_beat++; s_gbeat++;
          if (s_beat > s_len) s_active = 1'b0;
        end
        if (done) begin
          done_cnt++; done_cyc = cyc; err_at_done = error;
        end
      end
    end
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); cap_data.delete(); cap_last.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1; arv_cnt = 0; mirror_err = 0; stab_err = 0;
    s_gbeat = 0; err_at_done = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] a, input int n);
    @(negedge clk);
    clear_logs();
    start = 1'b1; start_addr = a; num_beats = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin to = 1'b0; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL reset_status got busy=%0b done=%0b error=%0b exp 0/0/0", busy, done, error); end
    total++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hs got arvalid=%0b rready=%0b out_valid=%0b exp 0/0/0", m_axi_arvalid, m_axi_rready, out_valid); end
    total++; if (m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0) begin
      bad++; $display("FAIL reset_ar got araddr=%h arlen=%0d exp 0/0", m_axi_araddr, m_axi_arlen); end
    total++; if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'h2 || m_axi_arprot !== 3'b010) begin
      bad++; $display("FAIL const_ar got size=%0d burst=%0d cache=%h prot=%0d exp 2/1/2/2", m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot); end
    rst = 1'b0;
  endtask

  task automatic test_split();
    bit to;
    logic [31:0] exp_a[3] = '{32'h1000, 32'h1040, 32'h1080};
    int exp_l[3] = '{15, 15, 7};
    run_cmd(32'h1000, 40);
    wait_done(400, to);
    total++; if (to) begin bad++; $display("FAIL split_timeout got no done exp done"); end
    total++; if (ar_addr_q.size() != 3) begin bad++; $display("FAIL split_nburst got=%0d exp=3", ar_addr_q.size()); end
    for (int i = 0; i < 3 && i < ar_addr_q.size(); i++) begin
      total++; if (ar_addr_q[i] !== exp_a[i] || ar_len_q[i] != exp_l[i]) begin
        bad++; $display("FAIL split_burst%0d got %h/%0d exp %h/%0d", i, ar_addr_q[i], ar_len_q[i], exp_a[i], exp_l[i]); end
    end
    total++; if (cap_data.size() != 40) begin bad++; $display("FAIL split_nbeats got=%0d exp=40", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++; if (cap_data[i] !== 32'h1000 + 32'(4 * i) || cap_last[i] !== (i == 39)) begin
        bad++; $display("FAIL split_beat%0d got %h last=%0b exp %h last=%0b", i, cap_data[i], cap_last[i], 32'h1000 + 32'(4 * i), (i == 39)); end
    end
    total++; if (done_cyc != last_cyc + 1 || done_cnt != 1) begin
      bad++; $display("FAIL split_done got cyc=%0d width=%0d exp cyc=%0d width=1", done_cyc, done_cnt, last_cyc + 1); end
    total++; if (error !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL split_end got error=%0b busy=%0b exp 0/0", error, busy); end
  endtask

  task automatic test_4k_boundary();
    bit to;
    ar_delay = 2;
    run_cmd(32'h1FF0, 8);
    wait_done(200, to);
    ar_delay = 0;
    total++; if (to || ar_addr_q.size() != 2) begin
      bad++; $display("FAIL bound_nburst got=%0d timeout=%0b exp 2/0", ar_addr_q.size(), to); end
    else begin
      total++; if (ar_addr_q[0] !== 32'h1FF0 || ar_len_q[0] != 3) begin
        bad++; $display("FAIL bound_burst0 got %h/%0d exp 1ff0/3", ar_addr_q[0], ar_len_q[0]); end
      total++; if (ar_addr_q[1] !== 32'h2000 || ar_len_q[1] != 3) begin
        bad++; $display("FAIL bound_burst1 got %h/%0d exp 2000/3", ar_addr_q[1], ar_len_q[1]); end
    end
    total++; if (stab_err != 0) begin bad++; $display("FAIL bound_ar_stable got changes=%0d exp 0", stab_err); end
    total++; if (cap_data.size() != 8 || cap_data[7] !== 32'h200C) begin
      bad++; $display("FAIL bound_beats got n=%0d exp n=8 last data 200c", cap_data.size()); end
  endtask

  task automatic test_backpressure();
    bit to = 1'b1;
    run_cmd(32'h1000, 40);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      out_ready = ~out_ready;
      if (done_cnt > 0) begin to = 1'b0; break; end
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got no done exp done"); end
    total++; if (mirror_err != 0) begin bad++; $display("FAIL bp_rready_mirror got errs=%0d exp 0", mirror_err); end
    total++; if (cap_data.size() != 40) begin bad++; $display("FAIL bp_nbeats got=%0d exp=40", cap_data.size()); end
    for (int i = 0; i < cap_data.size(); i++) begin
      total++; if (cap_data[i] !== 32'h1000 + 32'(4 * i) || cap_last[i] !== (i == 39)) begin
        bad++; $display("FAIL bp_beat%0d got %h last=%0b exp %h", i, cap_data[i], cap_last[i], 32'h1000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_errors();
    bit to;
    inj_rresp = 5;
    run_cmd(32'h0, 16);
    wait_done(200, to);
    inj_rresp = 0;
    total++; if (to || err_at_done !== 1'b1 || error !== 1'b1) begin
      bad++; $display("FAIL err_rresp got at_done=%0b after=%0b timeout=%0b exp 1/1/0", err_at_done, error, to); end
    run_cmd(32'h0, 16);
    total++; if (error !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL err_clear1 got error=%0b busy=%0b exp 0/1", error, busy); end
    wait_done(200, to);
    total++; if (to || error !== 1'b0) begin bad++; $display("FAIL err_clean got error=%0b exp 0", error); end
    inj_rlast = 3;
    run_cmd(32'h0, 16);
    wait_done(200, to);
    inj_rlast = 0;
    total++; if (to || err_at_done !== 1'b1 || error !== 1'b1) begin
      bad++; $display("FAIL err_rlast got at_done=%0b after=%0b exp 1/1", err_at_done, error); end
    total++; if (cap_data.size() != 16 || ar_addr_q.size() != 1) begin
      bad++; $display("FAIL err_rlast_count got beats=%0d bursts=%0d exp 16/1", cap_data.size(), ar_addr_q.size()); end
    run_cmd(32'h40, 4);
    total++; if (error !== 1'b0) begin bad++; $display("FAIL err_clear2 got error=%0b exp 0", error); end
    wait_done(100, to);
  endtask

  task automatic test_zero_and_busy_start();
    bit to;
    @(negedge clk);
    clear_logs();
    start = 1'b1; start_addr = 32'h2000; num_beats = '0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL zero_done got done=%0b busy=%0b exp 1/0", done, busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_pulse got done=%0b exp 0", done); end
    repeat (4) @(negedge clk);
    total++; if (arv_cnt != 0) begin bad++; $display("FAIL zero_noaxi got arvalid cycles=%0d exp 0", arv_cnt); end
    run_cmd(32'h1000, 40);
    repeat (5) @(negedge clk);
    start = 1'b1; start_addr = 32'h5000; num_beats = 16'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, to);
    total++; if (to || cap_data.size() != 40 || done_cnt != 1) begin
      bad++; $display("FAIL busy_start got beats=%0d dones=%0d exp 40/1", cap_data.size(), done_cnt); end
    total++; if (ar_addr_q.size() != 3 || ar_addr_q[0] !== 32'h1000) begin
      bad++; $display("FAIL busy_start_ar got bursts=%0d exp 3 from 1000", ar_addr_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    bit to = 1'b1;
    inj_rresp = 2;
    run_cmd(32'h1000, 40);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cap_data.size() >= 5) begin to = 1'b0; break; end
    end
    total++; if (to || error !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_pre got error=%0b busy=%0b exp 1/1", error, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL mid_reset got busy=%0b arvalid=%0b rready=%0b error=%0b exp 0/0/0/0", busy, m_axi_arvalid, m_axi_rready, error); end
    @(negedge clk);
    rst = 1'b0; inj_rresp = 0;
    run_cmd(32'h3000, 20);
    wait_done(300, to);
    total++; if (to || ar_addr_q.size() != 2) begin
      bad++; $display("FAIL mid_fresh got bursts=%0d timeout=%0b exp 2/0", ar_addr_q.size(), to); end
    else begin
      total++; if (ar_addr_q[0] !== 32'h3000 || ar_len_q[0] != 15 || ar_addr_q[1] !== 32'h3040 || ar_len_q[1] != 3) begin
        bad++; $display("FAIL mid_fresh_ar got %h/%0d %h/%0d exp 3000/15 3040/3", ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]); end
    end
    total++; if (cap_data.size() != 20 || cap_data[19] !== 32'h304C || cap_last[19] !== 1'b1 || error !== 1'b0) begin
      bad++; $display("FAIL mid_fresh_data got beats=%0d error=%0b exp 20 ending 304c, error 0", cap_data.size(), error); end
  endtask

  initial begin
    test_reset();
    test_split();
    test_4k_boundary();
    test_backpressure();
    test_errors();
    test_zero_and_busy_start();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dma_axi_rd_burst.md
Name: dma_axi_rd_burst

Overview:
Parametrised AXI4 read DMA engine. It takes a single command (start address, total beat count) and splits it into INCR bursts. Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary. Read data is delivered on a valid/ready stream with backpressure, and the block reports completion and sticky errors. It is the next-generation replacement for the single-burst read channel and sits between the DMA control registers and the AXI interconnect.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, data width in bits; power of 2, 8..1024
LEN_W, 8, arlen width (AXI4)
CNT_W, 16, width of the total beat count
MAX_BURST, 16, maximum beats per burst; power of 2, <= 2^LEN_W, <= 4096/(DATA_W/8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe; sampled only when busy=0
start_addr  in  ADDR_W  first byte address; low log2(DATA_W/8) bits forced to 0
num_beats  in  CNT_W  total beats to read
busy  out  1  command in progress
done  out  1  one-cycle pulse at command end
error  out  1  sticky error flag; cleared by accepted start
out_valid  out  1  stream data valid
out_data  out  DATA_W  stream data
out_last  out  1  final beat of whole command
out_ready  in  1  stream consumer ready
m_axi_arid/arlock/arqos  out  AXI widths  constant 0
m_axi_arcache, m_axi_arprot  out  4, 3  constants 4'h2, 3'b010
m_axi_araddr  out  ADDR_W  burst address
m_axi_arlen  out  LEN_W  beats-1 of current burst
m_axi_arsize  out  3  log2(DATA_W/8)
m_axi_arburst  out  2  2'b01 (INCR)
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of burst
m_axi_rvalid  in  1  read valid
m_axi_rready  out  1  read ready

Behaviour:
- Reset values: busy=0, done=0, error=0, m_axi_arvalid=0, m_axi_rready=0, out_valid=0, araddr=0, arlen=0, FSM=IDLE.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - start=1 with num_beats>0: latch address and remaining=num_beats, clear error, set busy=1 next cycle, go to ADDR.
  - start=1 with num_beats=0: done=1 next cycle, no AXI traffic, stay IDLE.
- ADDR:
  - Burst length is registered on entry: blen = min(remaining, MAX_BURST, beats to next 4 KB boundary), where beats to boundary = (4096 - addr[11:0]) >> log2(DATA_W/8).
  - arlen = blen-1. arvalid=1 until arready is sampled high. araddr/arlen are stable while arvalid=1.
  - On the handshake cycle go to DATA.
- DATA:
  - Combinational pass-through: out_valid=m_axi_rvalid, out_data=m_axi_rdata, m_axi_rready=out_ready. Zero added latency.
  - A beat is accepted when rvalid & rready. Each beat increments the burst beat counter.
  - On the beat where counter==blen-1: remaining -= blen, addr += blen*(DATA_W/8).
  - If remaining then becomes 0: done=1 on the next cycle, busy=0, go to IDLE. Otherwise go to ADDR.
  - out_last=1 when the accepted beat is the last beat of the last burst.
- Only one burst is outstanding at a time. start is ignored while busy=1.
- Error is set on any accepted beat where:
  - rresp != 0, or
  - rlast=1 on a non-final beat of the burst, or
  - rlast=0 on the final beat of the burst.
  The burst still terminates by beat count. Error stays set until the next accepted start.
- Address arithmetic wraps modulo 2^ADDR_W. Beat counter width is log2(MAX_BURST)+1.
- Asynchronous reset mid-operation returns the block to IDLE immediately. Quiescing outstanding AXI traffic is the system's responsibility.

Test Plan:
1. DATA_W=32, addr=0x1000, num_beats=40, arready and rvalid always 1, out_ready=1 -> bursts arlen=15,15,7 at 0x1000, 0x1040, 0x1080; 40 beats; out_last on beat 40; done 1 cycle after it; error=0.
2. addr=0x1FF0, num_beats=8 -> bursts arlen=3 @0x1FF0 then arlen=3 @0x2000; no burst crosses 4 KB.
3. out_ready toggled 1/0 every cycle with rvalid=1 -> rready mirrors out_ready; each beat delivered exactly once; 40 beats total, same data order.
4. rresp=2'b10 on beat 5, and separately rlast asserted on beat 3 of a 16-beat burst -> error=1 stays set through done; the next start clears it.
5. num_beats=0 with start -> done pulse next cycle, arvalid never asserted; start pulsed while busy -> ignored, beat count unchanged.
6. rst asserted in DATA mid-burst -> the next cycle has busy=0, arvalid=0, rready=0, error=0; a fresh command afterwards completes normally.
